// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns, enable codes,
// FSM encoding and small helpers for classifying enable codes.
package seven_seg_pkg;

    // Active-low a..g patterns, bit 6 = a, bit 0 = g.
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [2:0] EN_ONES = 3'b011;
    localparam logic [2:0] EN_TENS = 3'b110;
    localparam logic [2:0] EN_HUND = 3'b101;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == EN_ONES) || (code == EN_TENS) || (code == EN_HUND);
    endfunction

    // Slot index into the frame: 0 = ones, 1 = tens, 2 = hundreds.
    function automatic logic [1:0] code_slot(input logic [2:0] code);
        case (code)
            EN_TENS: return 2'd1;
            EN_HUND: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low a..g pattern back to a BCD digit.
module seg7_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'hF;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of the 3-digit multiplexed 7-segment interface: synchronizes ss/sse,
// captures one settled digit per enable phase and publishes complete 3-digit frames.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter bit          ENABLE_LAG     = 1'b1
) (
    input  logic        clk100m,
    input  logic        rst,
    input  logic [7:0]  ss,
    input  logic [2:0]  sse,
    output logic [11:0] bcd_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stalled
);

    logic [7:0]  ss_m, ss_s, ss_q;
    logic [2:0]  sse_m, sse_s, sse_q;
    logic [2:0]  last_code, prev_code;
    logic        last_ok, prev_ok;
    state_t      state, state_n;
    logic [31:0] stable_cnt, cnt_n;
    logic [31:0] idle_cnt;
    logic [11:0] digit_q;
    logic [2:0]  seen, seen_n, err, err_n;

    logic        sse_ok, sse_chg, ss_chg, valid_change;
    logic [2:0]  slot_code;
    logic        slot_ok;
    logic [1:0]  slot;
    logic        capture, stall_hit, frame_fire;
    logic        dec_ok;
    logic [3:0]  dec_digit;

    seg7_to_bcd u_dec (
        .seg   (ss_s[7:1]),
        .valid (dec_ok),
        .digit (dec_digit)
    );

    assign sse_ok       = code_valid(sse_s);
    assign sse_chg      = (sse_s != sse_q);
    assign ss_chg       = (ss_s != ss_q);
    assign valid_change = sse_ok && sse_chg;

    // With a registered driver the segments on screen belong to the previous digit.
    assign slot_code  = ENABLE_LAG ? prev_code : sse_s;
    assign slot_ok    = ENABLE_LAG ? prev_ok : 1'b1;
    assign slot       = code_slot(slot_code);

    assign stall_hit  = !valid_change && (idle_cnt == TIMEOUT_CYCLES - 1);
    assign frame_fire = (seen == 3'b111) && !stall_hit;

    always_comb begin
        state_n = state;
        cnt_n   = stable_cnt;
        capture = 1'b0;
        case (state)
            ST_WAIT: begin
                if (sse_ok) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
            end
            ST_SETTLE: begin
                if (ss_chg || sse_chg) begin
                    cnt_n = '0;
                end else if (stable_cnt == SETTLE_CYCLES - 1) begin
                    capture = slot_ok;
                    state_n = ST_HOLD;
                end else begin
                    cnt_n = stable_cnt + 1;
                end
            end
            ST_HOLD: begin
                if (sse_chg) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = ST_WAIT;
        endcase
        if (!sse_ok) begin
            state_n = ST_WAIT;
            cnt_n   = '0;
        end
    end

    // A capture landing in the frame or stall cycle survives into the fresh mask.
    always_comb begin
        seen_n = seen;
        err_n  = err;
        if (frame_fire || stall_hit) begin
            seen_n = '0;
            err_n  = '0;
        end
        if (capture) begin
            seen_n[slot] = 1'b1;
            err_n[slot]  = !dec_ok;
        end
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            ss_m        <= '0;
            ss_s        <= '0;
            ss_q        <= '0;
            sse_m       <= '0;
            sse_s       <= '0;
            sse_q       <= '0;
            last_code   <= EN_ONES;
            last_ok     <= 1'b0;
            prev_code   <= EN_ONES;
            prev_ok     <= 1'b0;
            state       <= ST_WAIT;
            stable_cnt  <= '0;
            idle_cnt    <= '0;
            digit_q     <= '0;
            seen        <= '0;
            err         <= '0;
            bcd_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            ss_m       <= ss;
            ss_s       <= ss_m;
            ss_q       <= ss_s;
            sse_m      <= sse;
            sse_s      <= sse_m;
            sse_q      <= sse_s;
            state      <= state_n;
            stable_cnt <= cnt_n;
            seen       <= seen_n;
            err        <= err_n;

            if (sse_ok) begin
                last_code <= sse_s;
                last_ok   <= 1'b1;
                if (last_ok && (sse_s != last_code)) begin
                    prev_code <= last_code;
                    prev_ok   <= 1'b1;
                end
            end

            if (capture) begin
                digit_q[{slot, 2'b00} +: 4] <= dec_ok ? dec_digit : 4'hF;
            end

            frame_valid <= frame_fire;
            if (frame_fire) begin
                bcd_out   <= digit_q;
                frame_err <= |err;
            end

            // Idle counter saturates at the timeout so stalled stays a clean level.
            if (valid_change) begin
                idle_cnt <= '0;
                stalled  <= 1'b0;
            end else if (idle_cnt != TIMEOUT_CYCLES) begin
                idle_cnt <= idle_cnt + 1;
                if (stall_hit) begin
                    stalled <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: one decoder with ENABLE_LAG=0 for most scenarios and a second
// with ENABLE_LAG=1 fed by a model of the registered counter driver.
module tb_seven_seg_scan_decoder;
    import seven_seg_pkg::*;

    localparam int unsigned SC = 4;
    localparam int unsigned TO = 200;
    localparam int PHASE = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ss, ss_l;
    logic [2:0]  sse, sse_l;
    logic [11:0] bcd, bcd_l;
    logic        fv, fe, st;
    logic        fv_l, fe_l, st_l;
    logic        fv_d = 1'b0;
    logic        fv_l_d = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_lag_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .ENABLE_LAG(1'b0)
    ) dut (
        .clk100m(clk), .rst(rst), .ss(ss), .sse(sse),
        .bcd_out(bcd), .frame_valid(fv), .frame_err(fe), .stalled(st)
    );

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .ENABLE_LAG(1'b1)
    ) dut_lag (
        .clk100m(clk), .rst(rst), .ss(ss_l), .sse(sse_l),
        .bcd_out(bcd_l), .frame_valid(fv_l), .frame_err(fe_l), .stalled(st_l)
    );

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return SEG_0;
            1: return SEG_1;
            2: return SEG_2;
            3: return SEG_3;
            4: return SEG_4;
            5: return SEG_5;
            6: return SEG_6;
            7: return SEG_7;
            8: return SEG_8;
            9: return SEG_9;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard: every frame_valid pops one expected {frame_err, bcd_out}.
    always @(negedge clk) begin : monitor
        logic [12:0] e;
        if (fv) begin
            checks++;
            if (fv_d) begin
                errors++;
                $display("FAIL frame_pulse_width frame_valid high two cycles in a row");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected got err=%b bcd=%h, no frame expected", fe, bcd);
            end else begin
                e = exp_q.pop_front();
                if ({fe, bcd} !== e) begin
                    errors++;
                    $display("FAIL frame got err=%b bcd=%h expected err=%b bcd=%h", fe, bcd, e[12], e[11:0]);
                end
            end
        end
        if (fv_l) begin
            checks++;
            if (fv_l_d) begin
                errors++;
                $display("FAIL lag_frame_pulse_width frame_valid high two cycles in a row");
            end else if (exp_lag_q.size() == 0) begin
                errors++;
                $display("FAIL lag_frame_unexpected got err=%b bcd=%h", fe_l, bcd_l);
            end else begin
                e = exp_lag_q.pop_front();
                if ({fe_l, bcd_l} !== e) begin
                    errors++;
                    $display("FAIL lag_frame got err=%b bcd=%h expected err=%b bcd=%h", fe_l, bcd_l, e[12], e[11:0]);
                end
            end
        end
        fv_d   = fv;
        fv_l_d = fv_l;
    end

    task automatic drive_phase(input logic [2:0] code, input logic [6:0] seg, input int cycles);
        @(negedge clk);
        sse = code;
        ss  = {seg, 1'($urandom_range(0, 1))};
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (40) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_frames got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_bcd_held(input string name, input logic [11:0] want);
        checks++;
        if (bcd !== want) begin
            errors++;
            $display("FAIL %s_held got bcd=%h expected %h", name, bcd, want);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({bcd, fv, fe, st} !== 15'd0 || {bcd_l, fv_l, fe_l, st_l} !== 15'd0) begin
            errors++;
            $display("FAIL %s got bcd=%h fv=%b fe=%b st=%b lag bcd=%h fv=%b fe=%b st=%b expected all 0",
                     name, bcd, fv, fe, st, bcd_l, fv_l, fe_l, st_l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ss = 8'hFF; sse = 3'b111; ss_l = 8'hFF; sse_l = 3'b111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
    endtask

    task automatic test_basic();
        exp_q.push_back({1'b0, 12'h123});
        drive_phase(EN_ONES, SEG_3, PHASE);
        drive_phase(EN_TENS, SEG_2, PHASE);
        drive_phase(EN_HUND, SEG_1, PHASE);
        drain("basic");
        check_bcd_held("basic", 12'h123);
    endtask

    task automatic test_all_zero();
        exp_q.push_back({1'b0, 12'h000});
        drive_phase(EN_ONES, SEG_0, PHASE);
        drive_phase(EN_TENS, SEG_0, PHASE);
        drive_phase(EN_HUND, SEG_0, PHASE);
        drain("all_zero");
        check_bcd_held("all_zero", 12'h000);
    endtask

    task automatic test_glitch();
        drive_phase(EN_ONES, SEG_4, PHASE);
        for (int i = 0; i < 8; i++) begin
            drive_phase(EN_TENS, (i % 2 == 0) ? SEG_5 : SEG_6, 3);
        end
        drive_phase(EN_HUND, SEG_8, PHASE);
        repeat (20) @(negedge clk);
        check_bcd_held("glitch_no_frame", 12'h000);
        exp_q.push_back({1'b0, 12'h854});
        drive_phase(EN_TENS, SEG_5, PHASE);
        drain("glitch");
    endtask

    task automatic test_blank();
        exp_q.push_back({1'b1, 12'h9F0});
        drive_phase(EN_ONES, SEG_0, PHASE);
        drive_phase(EN_TENS, 7'b1111111, PHASE);
        drive_phase(EN_HUND, SEG_9, PHASE);
        drain("blank");
    endtask

    task automatic test_reset_mid_frame();
        drive_phase(EN_ONES, SEG_5, PHASE);
        drive_phase(EN_TENS, SEG_6, PHASE);
        drive_phase(3'b111, 7'b1111111, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("reset_mid_frame");
        drive_phase(EN_HUND, SEG_7, PHASE);
        drive_phase(EN_ONES, SEG_1, PHASE);
        exp_q.push_back({1'b0, 12'h721});
        drive_phase(EN_TENS, SEG_2, PHASE);
        drain("reset_mid_frame");
    endtask

    task automatic test_stall();
        drive_phase(EN_ONES, SEG_1, PHASE);
        drive_phase(EN_TENS, SEG_7, 190);
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("FAIL stall_early got stalled=%b expected 0", st);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL stall_set got stalled=%b expected 1", st);
        end
        repeat (35) @(negedge clk);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got stalled=%b expected 1", st);
        end
        drive_phase(EN_HUND, SEG_2, 6);
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear got stalled=%b expected 0", st);
        end
        repeat (PHASE - 6) @(negedge clk);
        drive_phase(EN_ONES, SEG_1, PHASE);
        exp_q.push_back({1'b0, 12'h231});
        drive_phase(EN_TENS, SEG_3, PHASE);
        drain("stall");
    endtask

    task automatic test_lag();
        logic [2:0] codes[3];
        int digs[3];
        codes[0] = EN_ONES; codes[1] = EN_TENS; codes[2] = EN_HUND;
        digs[0] = 7; digs[1] = 0; digs[2] = 9;
        for (int f = 0; f < 3; f++) exp_lag_q.push_back({1'b0, 12'h907});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sse_l = codes[k % 3];
            ss_l  = {seg_pat(digs[(k + 2) % 3]), 1'b1};
            repeat (PHASE - 1) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (exp_lag_q.size() != 0) begin
            errors++;
            $display("FAIL lag_missing_frames got %0d pending expected 0", exp_lag_q.size());
        end
        checks++;
        if (bcd_l !== 12'h907) begin
            errors++;
            $display("FAIL lag_held got bcd=%h expected 907", bcd_l);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_glitch();
        test_blank();
        test_reset_mid_frame();
        test_stall();
        test_lag();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
